// File: rtl/bp_common_pkg.sv
// Shared link definitions for the front-end outbound LCE link stages.
// Provides the link message type, link FSM states and the link width macro.
`ifndef BP_COMMON_PKG_LINK_WIDTH
`define BP_COMMON_PKG_LINK_WIDTH
`define BP_FE_LCE_LINK_WIDTH(req_mp, resp_mp) (1 + (((req_mp) > (resp_mp)) ? (req_mp) : (resp_mp)))
`endif

package bp_common_pkg;

    // Type bit carried in the MSB of every link beat
    typedef enum logic {
        e_link_req  = 1'b0,
        e_link_resp = 1'b1
    } bp_link_msg_type_e;

    typedef enum logic {
        e_link_idle = 1'b0,
        e_link_send = 1'b1
    } bp_link_state_e;

endpackage

// File: rtl/bp_fe_lce_link_credit_counter.sv
// Downstream credit counter shared by the outbound link stages: starts full,
// decrements per grant, increments per returned credit, saturates at credits_p.
module bp_fe_lce_link_credit_counter #(
    parameter int unsigned credits_p = 4,
    localparam int unsigned cnt_width_lp = $clog2(credits_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    inc_i,
    input  logic                    dec_i,
    output logic [cnt_width_lp-1:0] credit_cnt_o
);

    localparam logic [cnt_width_lp-1:0] max_lp = cnt_width_lp'(credits_p);

    // Simultaneous grant and return leaves the count unchanged
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_cnt_o <= max_lp;
        end else if (inc_i && !dec_i) begin
            if (credit_cnt_o != max_lp) begin
                credit_cnt_o <= credit_cnt_o + cnt_width_lp'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (credit_cnt_o != '0) begin
                credit_cnt_o <= credit_cnt_o - cnt_width_lp'(1);
            end
        end
    end

    // A return with a full counter means the downstream over-returned credits
    credit_overflow_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(inc_i && !dec_i && (credit_cnt_o == max_lp)))
        else $error("credit return with counter already full");

endmodule

// File: rtl/bp_fe_lce_out_link.sv
// Outbound LCE link: merges request and response messages onto one credited
// link with response priority and request anti-starvation. Optional perf
// counters are enabled by defining BP_FE_LCE_OUT_LINK_PERF_EN.
module bp_fe_lce_out_link
    import bp_common_pkg::*;
#(
    parameter int unsigned req_width_p    = 128,
    parameter int unsigned resp_width_p   = 128,
    parameter int unsigned credits_p      = 4,
    parameter int unsigned starve_limit_p = 3,
    localparam int unsigned link_width_lp = `BP_FE_LCE_LINK_WIDTH(req_width_p, resp_width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [req_width_p-1:0]   lce_req_i,
    input  logic                     lce_req_v_i,
    output logic                     lce_req_ready_o,
    input  logic [resp_width_p-1:0]  lce_resp_i,
    input  logic                     lce_resp_v_i,
    output logic                     lce_resp_ready_o,
    output logic [link_width_lp-1:0] link_data_o,
    output logic                     link_v_o,
    input  logic                     credit_return_i
`ifdef BP_FE_LCE_OUT_LINK_PERF_EN
   ,output logic [31:0]              stall_cnt_o,
    output logic [15:0]              starve_evt_o
`endif
);

    localparam int unsigned payload_width_lp = link_width_lp - 1;
    localparam int unsigned cnt_width_lp     = $clog2(credits_p + 1);
    localparam int unsigned starve_width_lp  = $clog2(starve_limit_p + 1);
    localparam logic [starve_width_lp-1:0] starve_limit_lp = starve_width_lp'(starve_limit_p);

    bp_link_state_e             state_r, state_n;
    logic [link_width_lp-1:0]   link_data_r, link_data_n;
    logic [starve_width_lp-1:0] starve_cnt_r, starve_cnt_n;
    logic [cnt_width_lp-1:0]    credit_cnt;
    logic                       credit_ok;
    logic                       force_req;
    logic                       req_grant;
    logic                       resp_grant;
    logic                       grant;

    bp_fe_lce_link_credit_counter #(
        .credits_p (credits_p)
    ) u_credit (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .inc_i        (credit_return_i),
        .dec_i        (grant),
        .credit_cnt_o (credit_cnt)
    );

    // Grants use the registered count, so a same-cycle return cannot enable one
    assign credit_ok = reset_n_i & (credit_cnt != '0);
    assign force_req = lce_req_v_i & (starve_cnt_r == starve_limit_lp);

    assign lce_resp_ready_o = credit_ok & ~force_req;
    assign lce_req_ready_o  = credit_ok & (~lce_resp_v_i | force_req);

    assign resp_grant = lce_resp_v_i & lce_resp_ready_o;
    assign req_grant  = lce_req_v_i & lce_req_ready_o;
    assign grant      = resp_grant | req_grant;

    // Next-state, beat formation and starvation tracking
    always_comb begin
        state_n      = e_link_idle;
        link_data_n  = link_data_r;
        starve_cnt_n = starve_cnt_r;

        if (resp_grant) begin
            state_n     = e_link_send;
            link_data_n = {e_link_resp, payload_width_lp'(lce_resp_i)};
        end else if (req_grant) begin
            state_n     = e_link_send;
            link_data_n = {e_link_req, payload_width_lp'(lce_req_i)};
        end

        if (!lce_req_v_i || req_grant) begin
            starve_cnt_n = '0;
        end else if (resp_grant && (starve_cnt_r != starve_limit_lp)) begin
            starve_cnt_n = starve_cnt_r + starve_width_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= e_link_idle;
            link_data_r  <= '0;
            starve_cnt_r <= '0;
        end else begin
            state_r      <= state_n;
            link_data_r  <= link_data_n;
            starve_cnt_r <= starve_cnt_n;
        end
    end

    assign link_v_o    = (state_r == e_link_send);
    assign link_data_o = link_data_r;

`ifdef BP_FE_LCE_OUT_LINK_PERF_EN
    // Free-running event counters; both wrap naturally at their width
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_o  <= '0;
            starve_evt_o <= '0;
        end else begin
            if ((lce_req_v_i || lce_resp_v_i) && (credit_cnt == '0)) begin
                stall_cnt_o <= stall_cnt_o + 32'(1);
            end
            if (force_req) begin
                starve_evt_o <= starve_evt_o + 16'(1);
            end
        end
    end
`endif

endmodule
